intersect_nway_unit: RTL and testbench
======================================

# intersect_nway_unit

Parametrised N-input sparse joiner for the sparse tile datapath. It consumes NUM_IN coordinate/position stream pairs and emits a joined coordinate stream plus one position stream per input. It runs in intersection or union mode and carries stop, empty and done tokens. It is the generalised successor of the 2-input intersect unit and drops into the same glb_write/glb_read unit-test harness.

## Interface
Parameters:
- NUM_IN, 2: number of input channels, legal range 2..4.
- DATA_W, 16: payload width. Every stream word is DATA_W+1 bits; the MSB flags a control token.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  when low, the block holds all state.
- flush  in  1  synchronous clear, same effect as rst.
- tile_en  in  1  when low: all ready and valid outputs are 0 and state is held.
- joiner_op  in  1  0 = intersect, 1 = union. Sampled only in S_START.
- coord_in  in  NUM_IN×(DATA_W+1)  input coordinates; valid/ready per channel: coord_in_valid, coord_in_ready.
- pos_in  in  NUM_IN×(DATA_W+1)  input positions; valid/ready per channel: pos_in_valid, pos_in_ready.
- coord_out  out  DATA_W+1  joined coordinate, with coord_out_valid out / coord_out_ready in.
- pos_out  out  NUM_IN×(DATA_W+1)  per-channel positions, with pos_out_valid out / pos_out_ready in (NUM_IN bits each).
- proto_err  out  1  sticky flag for a protocol violation.

## Operation
- Tokens (MSB=1):
  - Stop level k: low bits = k, with k in 0..255.
  - Empty: 0x200.
  - Done: 0x100.
  - Data words have MSB=0.
- Channel head i is valid when coord_in_valid[i] && pos_in_valid[i]. A pop raises both coord_in_ready[i] and pos_in_ready[i] in the same cycle.
- A decision is taken only when every head is valid and the output bank can load.
- Decision rules, over data heads with minimum coordinate m:
  - All heads data, intersect: if all coordinates equal m, emit m and all positions, then pop all. Otherwise pop the channels holding m and emit nothing.
  - All heads data, union: emit m. For channels at m, emit their position and pop them. Other channels emit Empty and are not popped.
  - Mixed stop and data, intersect: pop the data channels and emit nothing.
  - Mixed stop and data, union: apply the union rule over the data channels only. Stopped channels emit Empty and are not popped.
  - All heads stop, same level: emit the stop token on coord_out and every pos_out, then pop all.
  - All heads stop, levels differ: emit the maximum level, pop all, set proto_err.
  - All heads Done: emit Done on all outputs, pop all, go to S_DONE.
  - Done mixed with anything else: set proto_err and treat Done as a stop level of 255.
- States:
  - S_START: proto_err is not cleared. Move to S_RUN on the first decision.
  - S_RUN: normal operation.
  - S_DONE: no pops. Return to S_START once the output bank has fully drained. The next tile then proceeds.

## Timing
- Output bank: one register set for coord_out and all pos_out, with a per-port pending bit.
- Loading the bank sets all valids together.
- Each port clears its valid independently when its own valid && ready handshake completes.
- The bank may load a new entry in the same cycle that the last pending port is accepted. Sustained throughput is therefore 1 decision per cycle.
- Latency: head pop to output valid is 1 cycle.
- Pops happen only in the same cycle as a bank load, except for intersect discards, which need no bank space.
- Reset/flush values: all valid and ready outputs 0, payloads 0, state S_START, proto_err 0. Reset mid-tile discards the bank contents.
- Inputs are never popped while tile_en=0 or clk_en=0.

## Structure
- Shared package `intersect_pkg` holds:
  - the token encodings (STOP_MASK, DONE_TOK, EMPTY_TOK);
  - the token classifier functions is_stop, is_done, stop_level;
  - the state enum.
- Sub-module `join_out_bank`: the registered multi-port output bank with per-port pending bits, parametrised by port count and width.
- The top level contains the head classifier, the minimum/compare tree and the FSM.

## Test plan
- Intersect, NUM_IN=2:
  - Stimulus: ch0 coords 1,3,5,S0,D with pos 10,11,12; ch1 coords 2,3,5,S0,D with pos 20,21,22.
  - Required: coord_out = 3,5,S0,D; pos_out0 = 11,12,S0,D; pos_out1 = 21,22,S0,D.
- Union, same stimulus:
  - Required: coord_out = 1,2,3,5,S0,D; pos_out0 = 10,E,11,12,S0,D; pos_out1 = E,20,21,22,S0,D.
- Backpressure with NUM_IN=3 intersect, coords 4,7 on all channels:
  - Hold pos_out_ready[1] low for 5 cycles while the other ports stay ready.
  - Required: no loss or duplication, and inputs stall.
  - With all ports ready, verify 1 output per cycle.
- Mismatched stops: ch0 S0, ch1 S1.
  - Required: S1 emitted on all ports and proto_err=1 until rst.
- Reset mid-tile: assert rst for 1 cycle while bank valid=1.
  - Required: next cycle all valids are 0 and state is S_START.
  - A second tile (coords 9,S0,D on both channels) must join correctly afterward.
- Back-to-back tiles (TX count 2):
  - Required: S_DONE → S_START transition, and Done emitted exactly once per tile.

Source files
------------

// File: rtl/intersect_pkg.sv
// Token encodings, token classifiers and FSM states shared by the N-way sparse joiner.
package intersect_pkg;

   localparam logic [31:0] STOP_MASK = 32'h0000_00FF;
   localparam logic [31:0] DONE_TOK  = 32'h0000_0100;
   localparam logic [31:0] EMPTY_TOK = 32'h0000_0200;

   typedef enum logic [1:0] {
      S_START,
      S_RUN,
      S_DONE
   } state_e;

   // Classifiers take the token flag and the zero-extended low payload bits.
   function automatic logic is_stop(input logic tok, input logic [31:0] low);
      return tok && ((low & ~STOP_MASK) == '0);
   endfunction

   function automatic logic is_done(input logic tok, input logic [31:0] low);
      return tok && (low == DONE_TOK);
   endfunction

   function automatic logic [7:0] stop_level(input logic [31:0] low);
      return 8'(low & STOP_MASK);
   endfunction

endpackage

// File: rtl/join_out_bank.sv
// Single-entry multi-port output register with a pending bit per port; ports drain independently.
module join_out_bank #(
   parameter int unsigned PORTS = 2,
   parameter int unsigned WIDTH = 17
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   load,
   input  logic [PORTS*WIDTH-1:0] load_data,
   input  logic [PORTS-1:0]       out_ready,
   output logic [PORTS*WIDTH-1:0] out_data,
   output logic [PORTS-1:0]       out_valid,
   output logic                   can_load,
   output logic                   idle
);

   logic [PORTS-1:0]       pend_q, pend_d;
   logic [PORTS*WIDTH-1:0] data_q, data_d;

   // A new entry may load in the same cycle the last pending port is accepted.
   always_comb begin
      out_valid = pend_q & {PORTS{en}};
      can_load  = en && ((pend_q & ~out_ready) == '0);
      idle      = (pend_q == '0);
      pend_d    = pend_q & ~(out_valid & out_ready);
      data_d    = data_q;
      if (load) begin
         pend_d = '1;
         data_d = load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
         data_q <= '0;
      end else if (en) begin
         pend_q <= pend_d;
         data_q <= data_d;
      end
   end

   assign out_data = data_q;

endmodule

// File: rtl/intersect_nway_unit.sv
// N-input sparse joiner: head classifier, minimum/compare tree and tile FSM feeding a shared output bank.
module intersect_nway_unit
   import intersect_pkg::*;
#(
   parameter int unsigned NUM_IN = 2,
   parameter int unsigned DATA_W = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clk_en,
   input  logic                           flush,
   input  logic                           tile_en,
   input  logic                           joiner_op,
   input  logic [NUM_IN*(DATA_W+1)-1:0]   coord_in,
   input  logic [NUM_IN-1:0]              coord_in_valid,
   output logic [NUM_IN-1:0]              coord_in_ready,
   input  logic [NUM_IN*(DATA_W+1)-1:0]   pos_in,
   input  logic [NUM_IN-1:0]              pos_in_valid,
   output logic [NUM_IN-1:0]              pos_in_ready,
   output logic [DATA_W:0]                coord_out,
   output logic                           coord_out_valid,
   input  logic                           coord_out_ready,
   output logic [NUM_IN*(DATA_W+1)-1:0]   pos_out,
   output logic [NUM_IN-1:0]              pos_out_valid,
   input  logic [NUM_IN-1:0]              pos_out_ready,
   output logic                           proto_err
);

   localparam int unsigned W = DATA_W + 1;
   localparam int unsigned P = NUM_IN + 1;

   function automatic logic [W-1:0] mk_tok(input logic [31:0] low);
      return {1'b1, DATA_W'(low)};
   endfunction

   state_e state_q, state_d;
   logic   op_q, op_d;
   logic   err_q, err_d;

   logic [W-1:0]        c_head [NUM_IN];
   logic [W-1:0]        p_head [NUM_IN];
   logic [7:0]          lvl    [NUM_IN];
   logic [NUM_IN-1:0]   is_data, at_min, pop_sel, pop;
   logic [DATA_W-1:0]   min_c;
   logic [7:0]          max_lvl;
   logic                any_done, all_done, lvl_same, bad_tok;
   logic                active, heads_ok, op_eff, fire, decide;
   logic                want_load, load, set_err, to_done;
   logic [W-1:0]        coord_ld;
   logic [NUM_IN*W-1:0] pos_ld;
   logic [P*W-1:0]      bank_data;
   logic [P-1:0]        bank_valid;
   logic                can_load, bank_idle;

   for (genvar g = 0; g < NUM_IN; g++) begin : g_head
      assign c_head[g] = coord_in[g*W +: W];
      assign p_head[g] = pos_in[g*W +: W];
   end

   assign active   = clk_en & tile_en;
   assign heads_ok = &(coord_in_valid & pos_in_valid);

   // Done alongside other heads is demoted to stop level 255.
   always_comb begin
      is_data  = '0;
      any_done = 1'b0;
      all_done = 1'b1;
      bad_tok  = 1'b0;
      min_c    = '1;
      max_lvl  = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         lvl[i] = 8'hFF;
         if (!c_head[i][DATA_W]) begin
            is_data[i] = 1'b1;
            all_done   = 1'b0;
            if (c_head[i][DATA_W-1:0] < min_c) min_c = c_head[i][DATA_W-1:0];
         end else if (is_done(1'b1, 32'(c_head[i][DATA_W-1:0]))) begin
            any_done = 1'b1;
         end else begin
            all_done = 1'b0;
            lvl[i]   = stop_level(32'(c_head[i][DATA_W-1:0]));
            if (!is_stop(1'b1, 32'(c_head[i][DATA_W-1:0]))) bad_tok = 1'b1;
         end
         if (!is_data[i] && (lvl[i] > max_lvl)) max_lvl = lvl[i];
      end
      lvl_same = 1'b1;
      at_min   = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         at_min[i] = is_data[i] && (c_head[i][DATA_W-1:0] == min_c);
         if (!is_data[i] && (lvl[i] != max_lvl)) lvl_same = 1'b0;
      end
   end

   always_comb begin
      op_eff    = (state_q == S_START) ? joiner_op : op_q;
      fire      = active && heads_ok && (state_q != S_DONE);
      want_load = 1'b0;
      pop_sel   = '0;
      set_err   = 1'b0;
      to_done   = 1'b0;
      coord_ld  = {1'b0, min_c};
      for (int unsigned i = 0; i < NUM_IN; i++) pos_ld[i*W +: W] = p_head[i];

      if (all_done) begin
         want_load = 1'b1;
         pop_sel   = '1;
         to_done   = 1'b1;
         coord_ld  = mk_tok(DONE_TOK);
         for (int unsigned i = 0; i < NUM_IN; i++) pos_ld[i*W +: W] = mk_tok(DONE_TOK);
      end else if (is_data == '0) begin
         want_load = 1'b1;
         pop_sel   = '1;
         set_err   = !lvl_same || any_done || bad_tok;
         coord_ld  = mk_tok(32'(max_lvl));
         for (int unsigned i = 0; i < NUM_IN; i++) pos_ld[i*W +: W] = mk_tok(32'(max_lvl));
      end else if (!op_eff) begin
         set_err = any_done || bad_tok;
         if ((&is_data) && (&at_min)) begin
            want_load = 1'b1;
            pop_sel   = '1;
         end else if (&is_data) begin
            pop_sel = at_min;
         end else begin
            pop_sel = is_data;
         end
      end else begin
         want_load = 1'b1;
         pop_sel   = at_min;
         set_err   = any_done || bad_tok;
         for (int unsigned i = 0; i < NUM_IN; i++)
            if (!at_min[i]) pos_ld[i*W +: W] = mk_tok(EMPTY_TOK);
      end

      // Intersect discards proceed without bank space; everything else needs a free bank.
      decide = fire && (!want_load || can_load);
      load   = decide && want_load;
      pop    = decide ? pop_sel : '0;

      state_d = state_q;
      op_d    = op_q;
      err_d   = err_q | (decide & set_err);
      if (active && (state_q == S_START)) op_d = joiner_op;
      case (state_q)
         S_START, S_RUN: if (decide) state_d = to_done ? S_DONE : S_RUN;
         S_DONE:         if (active && bank_idle) state_d = S_START;
         default:        state_d = S_START;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_q <= S_START;
         op_q    <= 1'b0;
         err_q   <= 1'b0;
      end else if (clk_en) begin
         state_q <= state_d;
         op_q    <= op_d;
         err_q   <= err_d;
      end
   end

   join_out_bank #(
      .PORTS (P),
      .WIDTH (W)
   ) u_bank (
      .clk       (clk),
      .rst       (rst | flush),
      .en        (active),
      .load      (load),
      .load_data ({pos_ld, coord_ld}),
      .out_ready ({pos_out_ready, coord_out_ready}),
      .out_data  (bank_data),
      .out_valid (bank_valid),
      .can_load  (can_load),
      .idle      (bank_idle)
   );

   assign coord_in_ready  = pop;
   assign pos_in_ready    = pop;
   assign coord_out       = bank_data[W-1:0];
   assign pos_out         = bank_data[P*W-1:W];
   assign coord_out_valid = bank_valid[0];
   assign pos_out_valid   = bank_valid[P-1:1];
   assign proto_err       = err_q;

endmodule

// File: tb/tb_intersect_nway_unit.sv
// Scoreboard bench: a 2-input and a 3-input joiner driven from per-channel source queues.
module tb_intersect_nway_unit;
   import intersect_pkg::*;

   localparam int W = 17;
   localparam logic [W-1:0] S0 = 17'h10000;
   localparam logic [W-1:0] S1 = 17'h10001;
   localparam logic [W-1:0] DN = 17'h10100;
   localparam logic [W-1:0] EM = 17'h10200;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [3*W-1:0] cin [2] = '{default: '0};
   logic [3*W-1:0] pin [2] = '{default: '0};
   logic [2:0]     cv  [2] = '{default: '0};
   logic [2:0]     pv  [2] = '{default: '0};
   logic [2:0]     ordy_p [2];
   logic           ordy_c [2];
   logic           jop    [2];

   logic [1:0]     u2_cr, u2_pr, u2_pov;
   logic [W-1:0]   u2_cout;
   logic [2*W-1:0] u2_pout;
   logic           u2_cov, u2_err;
   logic [2:0]     u3_cr, u3_pr, u3_pov;
   logic [W-1:0]   u3_cout;
   logic [3*W-1:0] u3_pout;
   logic           u3_cov, u3_err;

   logic [2:0]     cr   [2];
   logic [2:0]     pov  [2];
   logic [W-1:0]   cout [2];
   logic [3*W-1:0] pout [2];
   logic           cov  [2];
   logic           err  [2];

   assign cr[0]   = {1'b0, u2_cr};
   assign cr[1]   = u3_cr;
   assign pov[0]  = {1'b0, u2_pov};
   assign pov[1]  = u3_pov;
   assign cout[0] = u2_cout;
   assign cout[1] = u3_cout;
   assign pout[0] = {{W{1'b0}}, u2_pout};
   assign pout[1] = u3_pout;
   assign cov[0]  = u2_cov;
   assign cov[1]  = u3_cov;
   assign err[0]  = u2_err;
   assign err[1]  = u3_err;

   intersect_nway_unit #(.NUM_IN(2), .DATA_W(16)) u2 (
      .clk(clk), .rst(rst), .clk_en(1'b1), .flush(1'b0), .tile_en(1'b1), .joiner_op(jop[0]),
      .coord_in(cin[0][2*W-1:0]), .coord_in_valid(cv[0][1:0]), .coord_in_ready(u2_cr),
      .pos_in(pin[0][2*W-1:0]), .pos_in_valid(pv[0][1:0]), .pos_in_ready(u2_pr),
      .coord_out(u2_cout), .coord_out_valid(u2_cov), .coord_out_ready(ordy_c[0]),
      .pos_out(u2_pout), .pos_out_valid(u2_pov), .pos_out_ready(ordy_p[0][1:0]),
      .proto_err(u2_err)
   );

   intersect_nway_unit #(.NUM_IN(3), .DATA_W(16)) u3 (
      .clk(clk), .rst(rst), .clk_en(1'b1), .flush(1'b0), .tile_en(1'b1), .joiner_op(jop[1]),
      .coord_in(cin[1]), .coord_in_valid(cv[1]), .coord_in_ready(u3_cr),
      .pos_in(pin[1]), .pos_in_valid(pv[1]), .pos_in_ready(u3_pr),
      .coord_out(u3_cout), .coord_out_valid(u3_cov), .coord_out_ready(ordy_c[1]),
      .pos_out(u3_pout), .pos_out_valid(u3_pov), .pos_out_ready(ordy_p[1]),
      .proto_err(u3_err)
   );

   logic [W-1:0] src_c [2][3][$];
   logic [W-1:0] src_p [2][3][$];
   logic [W-1:0] exp_c [2][$];
   logic [W-1:0] exp_p [2][3][$];
   int           done_cnt [2] = '{0, 0};

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, expv);
      end
   endtask

   task automatic extra(input string nm, input logic [W-1:0] act);
      checks++;
      errors++;
      $display("FAIL %s: unexpected output %h, expected none", nm, act);
   endtask

   for (genvar u = 0; u < 2; u++) begin : g_io
      localparam int NCH = u + 2;
      logic [2:0] took;

      // Source driver: present queue heads, advance after an accepted pop.
      always begin
         @(negedge clk);
         took = cv[u] & cr[u];
         @(posedge clk);
         #1;
         for (int ch = 0; ch < NCH; ch++) begin
            if (took[ch] && src_c[u][ch].size() > 0) begin
               void'(src_c[u][ch].pop_front());
               void'(src_p[u][ch].pop_front());
            end
            if (src_c[u][ch].size() > 0) begin
               cin[u][ch*W +: W] = src_c[u][ch][0];
               pin[u][ch*W +: W] = src_p[u][ch][0];
               cv[u][ch] = 1'b1;
               pv[u][ch] = 1'b1;
            end else begin
               cv[u][ch] = 1'b0;
               pv[u][ch] = 1'b0;
            end
         end
      end

      // Monitor: every accepted output word is compared against the scoreboard.
      always @(negedge clk) begin
         if (cov[u] && ordy_c[u]) begin
            if (cout[u] == DN) done_cnt[u]++;
            if (exp_c[u].size() == 0) extra($sformatf("u%0d coord_out", u), cout[u]);
            else chk($sformatf("u%0d coord_out", u), cout[u], exp_c[u].pop_front());
         end
         for (int ch = 0; ch < NCH; ch++) begin
            if (pov[u][ch] && ordy_p[u][ch]) begin
               if (exp_p[u][ch].size() == 0)
                  extra($sformatf("u%0d pos_out%0d", u, ch), pout[u][ch*W +: W]);
               else
                  chk($sformatf("u%0d pos_out%0d", u, ch), pout[u][ch*W +: W], exp_p[u][ch].pop_front());
            end
         end
      end
   end

   state_e prev_st = S_START;
   int     start_cnt = 0;
   always @(negedge clk) begin
      if (prev_st == S_DONE && u2.state_q == S_START) start_cnt++;
      prev_st = u2.state_q;
   end

   task automatic push(input int u, input int ch, input logic [W-1:0] c, input logic [W-1:0] p);
      src_c[u][ch].push_back(c);
      src_p[u][ch].push_back(p);
   endtask

   task automatic expect_out(input int u, input logic [W-1:0] c, input logic [W-1:0] p0,
                             input logic [W-1:0] p1, input logic [W-1:0] p2);
      exp_c[u].push_back(c);
      exp_p[u][0].push_back(p0);
      exp_p[u][1].push_back(p1);
      if (u == 1) exp_p[u][2].push_back(p2);
   endtask

   task automatic basic_sources();
      push(0, 0, 1, 10); push(0, 0, 3, 11); push(0, 0, 5, 12); push(0, 0, S0, S0); push(0, 0, DN, DN);
      push(0, 1, 2, 20); push(0, 1, 3, 21); push(0, 1, 5, 22); push(0, 1, S0, S0); push(0, 1, DN, DN);
   endtask

   task automatic wait_drain(input int u, input int budget);
      int n = 0;
      while ((exp_c[u].size() + exp_p[u][0].size() + exp_p[u][1].size() + exp_p[u][2].size()) != 0
             && n < budget) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL drain u%0d: %0d words still expected after %0d cycles, required 0", u,
                  exp_c[u].size() + exp_p[u][0].size() + exp_p[u][1].size() + exp_p[u][2].size(), n);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int base_done, base_start, n, k;
      ordy_c = '{1'b1, 1'b1};
      ordy_p = '{3'b111, 3'b111};
      jop    = '{1'b0, 1'b0};

      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("u%0d reset coord_out_valid", u), 17'(cov[u]), 17'd0);
         chk($sformatf("u%0d reset pos_out_valid", u), 17'(pov[u]), 17'd0);
         chk($sformatf("u%0d reset coord_in_ready", u), 17'(cr[u]), 17'd0);
         chk($sformatf("u%0d reset proto_err", u), 17'(err[u]), 17'd0);
      end
      chk("u2 reset state", 17'(u2.state_q), 17'(S_START));
      @(posedge clk);
      #1 rst = 1'b0;

      // Two intersect tiles back to back on the 2-input unit.
      base_done  = done_cnt[0];
      base_start = start_cnt;
      for (int t = 0; t < 2; t++) begin
         basic_sources();
         expect_out(0, 3, 11, 21, 0);
         expect_out(0, 5, 12, 22, 0);
         expect_out(0, S0, S0, S0, 0);
         expect_out(0, DN, DN, DN, 0);
      end
      wait_drain(0, 300);
      chk("b2b done count", 17'(done_cnt[0] - base_done), 17'd2);
      chk("b2b done->start", 17'(start_cnt - base_start), 17'd2);

      // Union tile.
      jop[0] = 1'b1;
      basic_sources();
      expect_out(0, 1, 10, EM, 0);
      expect_out(0, 2, EM, 20, 0);
      expect_out(0, 3, 11, 21, 0);
      expect_out(0, 5, 12, 22, 0);
      expect_out(0, S0, S0, S0, 0);
      expect_out(0, DN, DN, DN, 0);
      wait_drain(0, 300);
      jop[0] = 1'b0;
      chk("u2 proto_err clean", 17'(err[0]), 17'd0);

      // Mismatched stop levels.
      push(0, 0, S0, S0); push(0, 0, DN, DN);
      push(0, 1, S1, S1); push(0, 1, DN, DN);
      expect_out(0, S1, S1, S1, 0);
      expect_out(0, DN, DN, DN, 0);
      wait_drain(0, 200);
      chk("mismatch proto_err", 17'(err[0]), 17'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("mismatch proto_err sticky", 17'(err[0]), 17'd1);

      // Backpressure on pos_out1 of the 3-input unit.
      ordy_p[1][1] = 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
         push(1, ch, 4, 17'(40 + ch));
         push(1, ch, 7, 17'(70 + ch));
         push(1, ch, S0, S0);
         push(1, ch, DN, DN);
      end
      expect_out(1, 4, 40, 41, 42);
      expect_out(1, 7, 70, 71, 72);
      expect_out(1, S0, S0, S0, S0);
      expect_out(1, DN, DN, DN, DN);
      n = 0;
      repeat (6) begin
         @(negedge clk);
         if (cv[1][0] && cr[1][0]) n++;
      end
      chk("backpressure pops", 17'(n), 17'd1);
      chk("backpressure held valid", 17'(pov[1][1]), 17'd1);
      @(posedge clk);
      #1 ordy_p[1][1] = 1'b1;
      wait_drain(1, 200);

      // Throughput with every port ready.
      for (int v = 1; v <= 5; v++) begin
         for (int ch = 0; ch < 3; ch++) push(1, ch, 17'(v), 17'(v * 10 + ch));
         expect_out(1, 17'(v), 17'(v * 10), 17'(v * 10 + 1), 17'(v * 10 + 2));
      end
      for (int ch = 0; ch < 3; ch++) begin
         push(1, ch, S0, S0);
         push(1, ch, DN, DN);
      end
      expect_out(1, S0, S0, S0, S0);
      expect_out(1, DN, DN, DN, DN);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(cov[1] && ordy_c[1]) && n < 50);
      k = (n < 50) ? 1 : 0;
      repeat (6) begin
         @(negedge clk);
         if (cov[1] && ordy_c[1]) k++;
      end
      chk("throughput outputs in 7 cycles", 17'(k), 17'd7);
      wait_drain(1, 200);

      // Reset while the bank holds an entry.
      ordy_c[0] = 1'b0;
      ordy_p[0] = 3'b000;
      push(0, 0, 5, 50);
      push(0, 1, 5, 51);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cov[0] && n < 20);
      chk("pre-reset bank valid", 17'(cov[0]), 17'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post-reset coord_out_valid", 17'(cov[0]), 17'd0);
      chk("post-reset pos_out_valid", 17'(pov[0]), 17'd0);
      chk("post-reset state", 17'(u2.state_q), 17'(S_START));
      chk("post-reset proto_err", 17'(err[0]), 17'd0);
      @(posedge clk);
      #1;
      ordy_c[0] = 1'b1;
      ordy_p[0] = 3'b111;
      push(0, 0, 9, 30); push(0, 0, S0, S0); push(0, 0, DN, DN);
      push(0, 1, 9, 40); push(0, 1, S0, S0); push(0, 1, DN, DN);
      expect_out(0, 9, 30, 40, 0);
      expect_out(0, S0, S0, S0, 0);
      expect_out(0, DN, DN, DN, 0);
      wait_drain(0, 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
